// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide unit with built-in M-extension decode
// Optional MULDIV_FAST_MUL_EN: MUL* ops use a single-cycle multiplier, DIV* ops stay iterative.
module muldiv_sequencer #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Start,
  input  logic             Flush,
  input  logic [1:0]       ALUOp,
  input  logic [6:0]       Funct7,
  input  logic [2:0]       Funct3,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  output logic             MulDivSel,
  output logic             Stall,
  output logic             Busy,
  output logic             Done,
  output logic [WIDTH-1:0] Result
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [2:0]         r_op;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_div0;
  logic               r_done;
  logic [WIDTH-1:0]   r_result;

  logic               w_accept;
  logic               w_last;
  logic               w_a_signed;
  logic               w_b_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_trial;
  logic               w_fits;
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   w_r;
  logic [WIDTH-1:0]   w_final;
`ifdef MULDIV_FAST_MUL_EN
  logic [2*WIDTH-1:0] w_fast_prod;
`endif

  assign MulDivSel = (ALUOp == 2'b10) && (Funct7 == 7'b0000001);
  assign Busy      = (r_state != S_IDLE);
  assign w_accept  = (r_state == S_IDLE) && Start && MulDivSel && !Flush;
  assign Stall     = w_accept || Busy;
  assign Done      = r_done;
  assign Result    = r_result;
  assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));

  // Signedness per Funct3: DIV/REM signed, MULH s*s, MULHSU s*u, rest unsigned.
  assign w_a_signed = Funct3[2] ? !Funct3[0] : (Funct3[1:0] == 2'b01 || Funct3[1:0] == 2'b10);
  assign w_b_signed = Funct3[2] ? !Funct3[0] : (Funct3[1:0] == 2'b01);
  assign w_a_neg    = w_a_signed && SrcA[WIDTH-1];
  assign w_b_neg    = w_b_signed && SrcB[WIDTH-1];
  assign w_a_mag    = w_a_neg ? ({WIDTH{1'b0}} - SrcA) : SrcA;
  assign w_b_mag    = w_b_neg ? ({WIDTH{1'b0}} - SrcB) : SrcB;

  // Shift-add step: {hi,lo} holds partial product and remaining multiplier bits.
  assign w_sum   = {1'b0, r_hi} + (r_lo[0] ? {1'b0, r_b} : {(WIDTH+1){1'b0}});
  // Restoring step; a zero divisor always "fits" so the remainder ends as |dividend|.
  assign w_trial = {r_hi, r_lo[WIDTH-1]} - {1'b0, r_b};
  assign w_fits  = r_div0 || !w_trial[WIDTH];

`ifdef MULDIV_FAST_MUL_EN
  assign w_fast_prod = {{WIDTH{1'b0}}, r_lo} * {{WIDTH{1'b0}}, r_b};
`endif

  assign w_prod_fix = r_neg_q ? ({(2*WIDTH){1'b0}} - {r_hi, r_lo}) : {r_hi, r_lo};
  assign w_q        = r_div0 ? {WIDTH{1'b1}} : (r_neg_q ? ({WIDTH{1'b0}} - r_lo) : r_lo);
  assign w_r        = r_neg_r ? ({WIDTH{1'b0}} - r_hi) : r_hi;

  always_comb begin
    w_final = w_r;
    case (r_op)
      3'b000:                 w_final = w_prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: w_final = w_prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         w_final = w_q;
      default:                w_final = w_r;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (Flush) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   if (w_accept) w_next = S_CALC;
        S_CALC: begin
          if (w_last) w_next = S_FINISH;
`ifdef MULDIV_FAST_MUL_EN
          if (!r_op[2]) w_next = S_FINISH;
`endif
        end
        S_FINISH: w_next = S_IDLE;
        default:  w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_op     <= '0;
      r_b      <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_div0   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      if (!Flush) begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_op    <= Funct3;
              r_b     <= w_b_mag;
              r_lo    <= w_a_mag;
              r_hi    <= '0;
              r_cnt   <= '0;
              r_neg_q <= w_a_neg ^ w_b_neg;
              r_neg_r <= w_a_neg;
              r_div0  <= Funct3[2] && (SrcB == '0);
            end
          end
          S_CALC: begin
            r_cnt <= r_cnt + 1'b1;
            if (r_op[2]) begin
              r_hi <= w_fits ? w_trial[WIDTH-1:0] : {r_hi[WIDTH-2:0], r_lo[WIDTH-1]};
              r_lo <= {r_lo[WIDTH-2:0], w_fits};
            end else begin
`ifdef MULDIV_FAST_MUL_EN
              {r_hi, r_lo} <= w_fast_prod;
`else
              r_hi <= w_sum[WIDTH:1];
              r_lo <= {w_sum[0], r_lo[WIDTH-1:1]};
`endif
            end
          end
          S_FINISH: begin
            r_result <= w_final;
            r_done   <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule
